// File: rtl/jt51_exp2lin_mix.sv
// Float-to-linear expander and CH-sample mixer for the DAC path, valid/ready in and out.
// Optional `JT51_EXP2LIN_SAT_EN: saturate the mixed frame and report clamping on ovf.
module jt51_exp2lin_mix #(
    parameter int unsigned MW = 10,
    parameter int unsigned EW = 3,
    parameter int unsigned OW = 16,
    parameter int unsigned CH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MW-1:0]         man,
    input  logic [EW-1:0]         exp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OW-1:0]         lin,
    output logic [$clog2(CH):0]   slot
`ifdef JT51_EXP2LIN_SAT_EN
    ,
    output logic                  ovf
`endif
);

    localparam int unsigned ACCW = OW + $clog2(CH);
    localparam int unsigned SW   = $clog2(CH) + 1;

    if (OW < MW + 2**EW - 2) begin : g_bad_ow
        $error("jt51_exp2lin_mix: OW too small for MW/EW");
    end
    if (CH < 1) begin : g_bad_ch
        $error("jt51_exp2lin_mix: CH must be >= 1");
    end

    logic            in_fire;
    logic            last_in;
    logic [SW-1:0]   slot_q, slot_d;
    logic [OW-1:0]   man_ext, x_d;

    logic            s1_valid_q, s1_valid_d;
    logic            s1_last_q;
    logic [OW-1:0]   s1_x_q;
    logic            consume;

    logic [ACCW-1:0] acc_q, acc_d, sum;
    logic [OW-1:0]   lin_q, lin_d, fmt_lin;
    logic            out_valid_q, out_valid_d;
    logic            fmt_ovf;

    assign in_ready = ~out_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign last_in  = (slot_q == SW'(CH - 1));

    // Stage 1: expansion and input-side channel count
    always_comb begin
        man_ext = OW'($signed(man));
        x_d     = '0;
        if (exp != '0) begin
            x_d = man_ext << (exp - EW'(1));
        end
        slot_d = slot_q;
        if (in_fire) begin
            slot_d = last_in ? '0 : slot_q + SW'(1);
        end
    end

    // A last sample only waits when a previous frame is still stalled (reachable with CH=1).
    assign consume    = s1_valid_q & ~(s1_last_q & out_valid_q & ~out_ready);
    assign s1_valid_d = in_fire | (s1_valid_q & ~consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
            slot_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            slot_q     <= slot_d;
            if (in_fire) begin
                s1_x_q    <= x_d;
                s1_last_q <= last_in;
            end
        end
    end

    // Stage 2: accumulate and format
    assign sum = acc_q + ACCW'($signed(s1_x_q));

`ifdef JT51_EXP2LIN_SAT_EN
    localparam logic [ACCW-1:0] SMAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic [ACCW-1:0] SMIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        fmt_lin = sum[OW-1:0];
        fmt_ovf = 1'b0;
        if ($signed(sum) > $signed(SMAX)) begin
            fmt_lin = SMAX[OW-1:0];
            fmt_ovf = 1'b1;
        end else if ($signed(sum) < $signed(SMIN)) begin
            fmt_lin = SMIN[OW-1:0];
            fmt_ovf = 1'b1;
        end
    end
`else
    logic sum_unused;
    assign sum_unused = ^sum;
    assign fmt_lin    = sum[OW-1:0];
    assign fmt_ovf    = 1'b0;
`endif

    always_comb begin
        acc_d       = acc_q;
        lin_d       = lin_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (consume) begin
            if (s1_last_q) begin
                lin_d       = fmt_lin;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            lin_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            lin_q       <= lin_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef JT51_EXP2LIN_SAT_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (consume && s1_last_q) begin
            ovf_q <= fmt_ovf;
        end
    end
    assign ovf = ovf_q;
`else
    logic fmt_ovf_unused;
    assign fmt_ovf_unused = fmt_ovf;
`endif

    assign out_valid = out_valid_q;
    assign lin       = lin_q;
    assign slot      = slot_q;

endmodule
